// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
// Bundles every non-clock/non-reset signal of the program loader.
//   slave  : the loader itself (consumes host commands, drives memories,
//            CPU control, dump stream and status).
//   master : the surrounding system (host, load/dump streams, memories, CPU).
// Signal groups:
//   host     : go, n_inst, n_data, n_dump
//   load     : in_valid, in_ready, in_data
//   imem     : imem_we, imem_addr, imem_wdata
//   dmem     : dmem_we, dmem_re, dmem_addr, dmem_wdata, dmem_rdata
//   cpu      : cpu_start, cpu_halt
//   dump     : out_valid, out_ready, out_data
//   status   : cycles, busy, done, timeout
// ---------------------------------------------------------------------------
interface prog_loader_if #(
  parameter int IW = 9,
  parameter int IA = 16,
  parameter int DW = 8,
  parameter int DA = 8
);
  logic          go;
  logic [IA-1:0] n_inst;
  logic [DA-1:0] n_data;
  logic [DA-1:0] n_dump;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          imem_we;
  logic [IA-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic          dmem_we;
  logic          dmem_re;
  logic [DA-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          cpu_start;
  logic          cpu_halt;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [15:0]   cycles;
  logic          busy;
  logic          done;
  logic          timeout;

  modport slave (
    input  go, n_inst, n_data, n_dump, in_valid, in_data, dmem_rdata,
           cpu_halt, out_ready,
    output in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_re,
           dmem_addr, dmem_wdata, cpu_start, out_valid, out_data, cycles,
           busy, done, timeout
  );

  modport master (
    output go, n_inst, n_data, n_dump, in_valid, in_data, dmem_rdata,
           cpu_halt, out_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_re,
           dmem_addr, dmem_wdata, cpu_start, out_valid, out_data, cycles,
           busy, done, timeout
  );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Loads a program into instruction memory and a data image into data memory
// from one valid/ready stream, holds the CPU in start/reset while loading,
// runs it until halt, then streams a region of data memory back out.
// Ports:
//   clk    : single clock, all state changes on posedge
//   start  : synchronous active-high reset
//   bus    : prog_loader_if.slave (host, load stream, imem, dmem, cpu,
//            dump stream, status)
// Parameters: IW/IA instruction width/address, DW/DA data width/address,
//   MAXCYC run-cycle limit (used only with the timeout option).
// Build option: define LOADER_TIMEOUT_EN to let RUN give up after MAXCYC
//   cycles without a halt and raise timeout; otherwise RUN waits forever
//   and timeout stays 0.
// Parameters must match those of the connected interface instance.
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int          IW     = 9,
  parameter int          IA     = 16,
  parameter int          DW     = 8,
  parameter int          DA     = 8,
  parameter logic [15:0] MAXCYC = 16'hFFFF
) (
  input logic          clk,
  input logic          start,
  prog_loader_if.slave bus
);

`ifdef LOADER_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  localparam logic [IA-1:0] IA_ZERO = {IA{1'b0}};
  localparam logic [IA-1:0] IA_ONE  = {{(IA-1){1'b0}}, 1'b1};
  localparam logic [DA-1:0] DA_ZERO = {DA{1'b0}};
  localparam logic [DA-1:0] DA_ONE  = {{(DA-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0] DW_ZERO = {DW{1'b0}};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_I   = 3'd1,
    LOAD_D   = 3'd2,
    START    = 3'd3,
    RUN      = 3'd4,
    DUMP_RD  = 3'd5,
    DUMP_OUT = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t        state_r,     state_nx_s;
  logic [IA-1:0] idx_r,       idx_nx_s;      // instruction load index
  logic [DA-1:0] k_r,         k_nx_s;        // data load / dump index
  logic [IA-1:0] n_inst_r,    n_inst_nx_s;
  logic [DA-1:0] n_data_r,    n_data_nx_s;
  logic [DA-1:0] n_dump_r,    n_dump_nx_s;
  logic [15:0]   cycles_r,    cycles_nx_s;
  logic          timeout_r,   timeout_nx_s;
  logic [DW-1:0] out_data_r,  out_data_nx_s;
  logic          start_cnt_r, start_cnt_nx_s; // second START cycle marker
  logic          rd_pend_r,   rd_pend_nx_s;   // dmem_rdata valid this cycle
  logic          imem_we_s;
  logic          dmem_we_s;
  logic [IW-1:0] in_word_s;

  assign in_word_s = bus.in_data;

  // State and datapath registers; start clears everything back to IDLE.
  always_ff @(posedge clk) begin
    if (start) begin
      state_r     <= IDLE;
      idx_r       <= IA_ZERO;
      k_r         <= DA_ZERO;
      n_inst_r    <= IA_ZERO;
      n_data_r    <= DA_ZERO;
      n_dump_r    <= DA_ZERO;
      cycles_r    <= 16'd0;
      timeout_r   <= 1'b0;
      out_data_r  <= DW_ZERO;
      start_cnt_r <= 1'b0;
      rd_pend_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      idx_r       <= idx_nx_s;
      k_r         <= k_nx_s;
      n_inst_r    <= n_inst_nx_s;
      n_data_r    <= n_data_nx_s;
      n_dump_r    <= n_dump_nx_s;
      cycles_r    <= cycles_nx_s;
      timeout_r   <= timeout_nx_s;
      out_data_r  <= out_data_nx_s;
      start_cnt_r <= start_cnt_nx_s;
      rd_pend_r   <= rd_pend_nx_s;
    end
  end

  // Next-state, next-datapath and memory write strobes.
  always_comb begin
    state_nx_s     = state_r;
    idx_nx_s       = idx_r;
    k_nx_s         = k_r;
    n_inst_nx_s    = n_inst_r;
    n_data_nx_s    = n_data_r;
    n_dump_nx_s    = n_dump_r;
    cycles_nx_s    = cycles_r;
    timeout_nx_s   = timeout_r;
    out_data_nx_s  = out_data_r;
    start_cnt_nx_s = 1'b0;
    rd_pend_nx_s   = 1'b0;
    imem_we_s      = 1'b0;
    dmem_we_s      = 1'b0;

    case (state_r)
      IDLE, DONE: begin
        if (bus.go) begin
          n_inst_nx_s  = bus.n_inst;
          n_data_nx_s  = bus.n_data;
          n_dump_nx_s  = bus.n_dump;
          idx_nx_s     = IA_ZERO;
          k_nx_s       = DA_ZERO;
          cycles_nx_s  = 16'd0;
          timeout_nx_s = 1'b0;
          // Skip any load phase with nothing to load.
          if (bus.n_inst != IA_ZERO) begin
            state_nx_s = LOAD_I;
          end else if (bus.n_data != DA_ZERO) begin
            state_nx_s = LOAD_D;
          end else begin
            state_nx_s = START;
          end
        end else begin
          state_nx_s = state_r;
        end
      end

      LOAD_I: begin
        if (bus.in_valid) begin
          imem_we_s = 1'b1;
          if (idx_r == (n_inst_r - IA_ONE)) begin
            idx_nx_s = IA_ZERO;
            if (n_data_r != DA_ZERO) begin
              state_nx_s = LOAD_D;
            end else begin
              state_nx_s = START;
            end
          end else begin
            idx_nx_s = idx_r + IA_ONE;
          end
        end else begin
          imem_we_s = 1'b0;
        end
      end

      LOAD_D: begin
        if (bus.in_valid) begin
          dmem_we_s = 1'b1;
          if (k_r == (n_data_r - DA_ONE)) begin
            // k is reused as the dump index, so rewind it here.
            k_nx_s     = DA_ZERO;
            state_nx_s = START;
          end else begin
            k_nx_s = k_r + DA_ONE;
          end
        end else begin
          dmem_we_s = 1'b0;
        end
      end

      START: begin
        if (start_cnt_r) begin
          state_nx_s  = RUN;
          cycles_nx_s = 16'd0;
        end else begin
          start_cnt_nx_s = 1'b1;
        end
      end

      RUN: begin
        if (bus.cpu_halt) begin
          if (n_dump_r != DA_ZERO) begin
            state_nx_s = DUMP_RD;
          end else begin
            state_nx_s = DONE;
          end
        end else if (TMO_EN && (cycles_r == MAXCYC)) begin
          timeout_nx_s = 1'b1;
          if (n_dump_r != DA_ZERO) begin
            state_nx_s = DUMP_RD;
          end else begin
            state_nx_s = DONE;
          end
        end else if (cycles_r != 16'hFFFF) begin
          cycles_nx_s = cycles_r + 16'd1;
        end else begin
          cycles_nx_s = cycles_r;
        end
      end

      DUMP_RD: begin
        rd_pend_nx_s = 1'b1;
        state_nx_s   = DUMP_OUT;
      end

      DUMP_OUT: begin
        // First DUMP_OUT cycle only captures the read data; out_valid
        // rises once the byte sits in out_data_r.
        if (rd_pend_r) begin
          out_data_nx_s = bus.dmem_rdata;
        end else if (bus.out_ready) begin
          k_nx_s = k_r + DA_ONE;
          if (k_r == (n_dump_r - DA_ONE)) begin
            state_nx_s = DONE;
          end else begin
            state_nx_s = DUMP_RD;
          end
        end else begin
          out_data_nx_s = out_data_r;
        end
      end

      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  assign bus.in_ready   = (state_r == LOAD_I) || (state_r == LOAD_D);
  assign bus.imem_we    = imem_we_s;
  assign bus.imem_addr  = idx_r;
  assign bus.imem_wdata = in_word_s;
  assign bus.dmem_we    = dmem_we_s;
  assign bus.dmem_re    = (state_r == DUMP_RD);
  assign bus.dmem_addr  = k_r;
  assign bus.dmem_wdata = in_word_s[DW-1:0];
  assign bus.cpu_start  = (state_r == IDLE) || (state_r == LOAD_I) ||
                          (state_r == LOAD_D) || (state_r == START);
  assign bus.out_valid  = (state_r == DUMP_OUT) && !rd_pend_r;
  assign bus.out_data   = out_data_r;
  assign bus.cycles     = cycles_r;
  assign bus.busy       = (state_r != IDLE) && (state_r != DONE);
  assign bus.done       = (state_r == DONE);
  assign bus.timeout    = timeout_r;

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader. Behavioural imem/dmem and a CPU model
// that halts a set number of cycles after cpu_start falls. Expected memory
// writes and dump bytes are queued when stimulus is driven and popped by a
// monitor when the DUT produces them. Instantiated with MAXCYC=20.
// ---------------------------------------------------------------------------
module tb_prog_loader;
  localparam int IW = 9;
  localparam int IA = 16;
  localparam int DW = 8;
  localparam int DA = 8;

  logic clk;
  logic start;

  prog_loader_if #(.IW(IW), .IA(IA), .DW(DW), .DA(DA)) bus ();

  prog_loader #(.IW(IW), .IA(IA), .DW(DW), .DA(DA), .MAXCYC(16'd20)) dut (
    .clk   (clk),
    .start (start),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int halt_after = 1000;
  int run_cnt = 0;
  int imem_wr_cnt = 0;
  int dmem_wr_cnt = 0;
  int strobe_cnt = 0;
  int out_cnt = 0;

  logic [IA+IW-1:0] exp_imem [$];
  logic [DA+DW-1:0] exp_dmem [$];
  logic [DW-1:0]    exp_out  [$];
  logic [IA+IW-1:0] mon_ei;
  logic [DA+DW-1:0] mon_ed;
  logic [DW-1:0]    mon_eo;

  logic [IW-1:0] imem_mem [0:15];
  logic [DW-1:0] dmem_mem [0:15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memories: write on posedge, read data one cycle after dmem_re.
  always @(posedge clk) begin
    if (bus.imem_we === 1'b1) imem_mem[bus.imem_addr[3:0]] <= bus.imem_wdata;
    if (bus.dmem_we === 1'b1) dmem_mem[bus.dmem_addr[3:0]] <= bus.dmem_wdata;
    if (bus.dmem_re === 1'b1) bus.dmem_rdata <= dmem_mem[bus.dmem_addr[3:0]];
  end

  // CPU model: counts cycles since cpu_start fell, halts after halt_after.
  always @(posedge clk) begin
    #1;
    if (bus.cpu_start !== 1'b0) begin
      run_cnt = 0;
      bus.cpu_halt = 1'b0;
    end else begin
      run_cnt = run_cnt + 1;
      bus.cpu_halt = (run_cnt > halt_after);
    end
  end

  // Scoreboard monitor: pops expected writes / dump bytes as they appear.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      imem_wr_cnt++;
      checks++;
      if (exp_imem.size() == 0) begin
        errors++;
        $display("FAIL imem_write: addr=%0h data=%0h, required no write", bus.imem_addr, bus.imem_wdata);
      end else begin
        mon_ei = exp_imem.pop_front();
        if ({bus.imem_addr, bus.imem_wdata} !== mon_ei) begin
          errors++;
          $display("FAIL imem_write: addr=%0h data=%0h, required addr=%0h data=%0h",
                   bus.imem_addr, bus.imem_wdata, mon_ei[IA+IW-1:IW], mon_ei[IW-1:0]);
        end
      end
    end
    if (bus.dmem_we === 1'b1) begin
      dmem_wr_cnt++;
      checks++;
      if (exp_dmem.size() == 0) begin
        errors++;
        $display("FAIL dmem_write: addr=%0h data=%0h, required no write", bus.dmem_addr, bus.dmem_wdata);
      end else begin
        mon_ed = exp_dmem.pop_front();
        if ({bus.dmem_addr, bus.dmem_wdata} !== mon_ed) begin
          errors++;
          $display("FAIL dmem_write: addr=%0h data=%0h, required addr=%0h data=%0h",
                   bus.dmem_addr, bus.dmem_wdata, mon_ed[DA+DW-1:DW], mon_ed[DW-1:0]);
        end
      end
    end
    if ((bus.imem_we === 1'b1) || (bus.dmem_we === 1'b1) || (bus.dmem_re === 1'b1)) begin
      strobe_cnt++;
      checks++;
      if (((bus.imem_we === 1'b1 || bus.dmem_we === 1'b1) && bus.in_ready !== 1'b1) ||
          (bus.dmem_we === 1'b1 && bus.dmem_re === 1'b1)) begin
        errors++;
        $display("FAIL strobe_legal: we_i=%b we_d=%b re=%b in_ready=%b, required writes only while loading",
                 bus.imem_we, bus.dmem_we, bus.dmem_re, bus.in_ready);
      end
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      out_cnt++;
      checks++;
      if (exp_out.size() == 0) begin
        errors++;
        $display("FAIL dump_byte: out_data=%0h, required no output", bus.out_data);
      end else begin
        mon_eo = exp_out.pop_front();
        if (bus.out_data !== mon_eo) begin
          errors++;
          $display("FAIL dump_byte: out_data=%0h, required %0h", bus.out_data, mon_eo);
        end
      end
    end
  end

  task automatic start_session(input logic [IA-1:0] ni, input logic [DA-1:0] nd, input logic [DA-1:0] ndp);
    @(posedge clk); #1;
    bus.n_inst = ni;
    bus.n_data = nd;
    bus.n_dump = ndp;
    bus.go     = 1'b1;
    @(posedge clk); #1;
    bus.go     = 1'b0;
  endtask

  task automatic send_word(input logic [IW-1:0] w);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: in_ready=%b, required 1 within 20 cycles", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int t;
    t = 0;
    ok = 1'b0;
    while (t < limit && !ok) begin
      @(negedge clk);
      if (bus.done === 1'b1) ok = 1'b1;
      else t++;
    end
  endtask

  task automatic test_reset;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cpu_start, bus.busy, bus.done, bus.timeout} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_status: {cpu_start,busy,done,timeout}=%b, required 1000",
               {bus.cpu_start, bus.busy, bus.done, bus.timeout});
    end
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.imem_we, bus.dmem_we, bus.dmem_re} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_strobes: {in_ready,out_valid,imem_we,dmem_we,dmem_re}=%b, required 00000",
               {bus.in_ready, bus.out_valid, bus.imem_we, bus.dmem_we, bus.dmem_re});
    end
    checks++;
    if (bus.cycles !== 16'd0 || bus.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: cycles=%0d out_data=%0h, required 0 and 0", bus.cycles, bus.out_data);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_start, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL idle_hold: {cpu_start,busy}=%b, required 10", {bus.cpu_start, bus.busy});
    end
  endtask

  task automatic test_full_session;
    int  cnt;
    bit  ok;
    halt_after = 10;
    bus.out_ready = 1'b1;
    exp_out.push_back(8'h11);
    exp_out.push_back(8'h22);
    start_session(16'd3, 8'd2, 8'd2);
    exp_imem.push_back({16'd0, 9'h1A5}); send_word(9'h1A5);
    exp_imem.push_back({16'd1, 9'h040}); send_word(9'h040);
    exp_imem.push_back({16'd2, 9'h1FF}); send_word(9'h1FF);
    exp_dmem.push_back({8'd0, 8'h11});   send_word(9'h011);
    exp_dmem.push_back({8'd1, 8'h22});   send_word(9'h022);
    cnt = 0;
    @(negedge clk);
    while (bus.cpu_start === 1'b1 && cnt < 10) begin
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != 2) begin
      errors++;
      $display("FAIL start_len: START cycles=%0d, required 2", cnt);
    end
    checks++;
    if ({bus.cpu_start, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL run_entry: {cpu_start,busy}=%b, required 01", {bus.cpu_start, bus.busy});
    end
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_done: done=%b, required 1 within 200 cycles", bus.done);
    end
    checks++;
    if (bus.cycles !== 16'd10 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL full_cycles: cycles=%0d timeout=%b, required 10 and 0", bus.cycles, bus.timeout);
    end
    checks++;
    if ({imem_mem[0], imem_mem[1], imem_mem[2]} !== {9'h1A5, 9'h040, 9'h1FF}) begin
      errors++;
      $display("FAIL full_imem: %h %h %h, required 1a5 040 1ff", imem_mem[0], imem_mem[1], imem_mem[2]);
    end
    checks++;
    if (exp_out.size() != 0 || exp_imem.size() != 0 || exp_dmem.size() != 0) begin
      errors++;
      $display("FAIL full_drain: pending out=%0d imem=%0d dmem=%0d, required 0",
               exp_out.size(), exp_imem.size(), exp_dmem.size());
    end
  endtask

  task automatic test_backpressure;
    int t;
    bit ok;
    halt_after  = 3;
    imem_wr_cnt = 0;
    dmem_wr_cnt = 0;
    bus.out_ready = 1'b0;
    exp_out.push_back(8'hA5);
    exp_out.push_back(8'h5A);
    start_session(16'd2, 8'd2, 8'd2);
    exp_imem.push_back({16'd0, 9'h0F0}); send_word(9'h0F0); @(posedge clk); #1;
    exp_imem.push_back({16'd1, 9'h10F}); send_word(9'h10F); @(posedge clk); #1;
    exp_dmem.push_back({8'd0, 8'hA5});   send_word(9'h0A5); @(posedge clk); #1;
    exp_dmem.push_back({8'd1, 8'h5A});   send_word(9'h05A); @(posedge clk); #1;
    t = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b out_data=%0h, required 1 and a5", i, bus.out_valid, bus.out_data);
      end
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_done: done=%b, required 1 within 100 cycles", bus.done);
    end
    checks++;
    if (imem_wr_cnt != 2 || dmem_wr_cnt != 2) begin
      errors++;
      $display("FAIL bp_counts: imem writes=%0d dmem writes=%0d, required 2 and 2", imem_wr_cnt, dmem_wr_cnt);
    end
    checks++;
    if ({imem_mem[0], imem_mem[1], dmem_mem[0], dmem_mem[1]} !== {9'h0F0, 9'h10F, 8'hA5, 8'h5A}) begin
      errors++;
      $display("FAIL bp_mem: %h %h %h %h, required 0f0 10f a5 5a", imem_mem[0], imem_mem[1], dmem_mem[0], dmem_mem[1]);
    end
    checks++;
    if (exp_out.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: pending out=%0d, required 0", exp_out.size());
    end
  endtask

  task automatic test_zero_counts;
    bit ok;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.cycles !== 16'd3) begin
      errors++;
      $display("FAIL done_hold: done=%b cycles=%0d, required 1 and 3", bus.done, bus.cycles);
    end
    halt_after = 2;
    strobe_cnt = 0;
    out_cnt    = 0;
    start_session(16'd0, 8'd0, 8'd0);
    @(negedge clk);
    checks++;
    if ({bus.cpu_start, bus.busy, bus.in_ready, bus.done} !== 4'b1100 || bus.cycles !== 16'd0) begin
      errors++;
      $display("FAIL zero_start: {cpu_start,busy,in_ready,done}=%b cycles=%0d, required 1100 and 0",
               {bus.cpu_start, bus.busy, bus.in_ready, bus.done}, bus.cycles);
    end
    wait_done(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_done: done=%b, required 1 within 50 cycles", bus.done);
    end
    checks++;
    if (strobe_cnt != 0 || out_cnt != 0 || bus.cycles !== 16'd2) begin
      errors++;
      $display("FAIL zero_quiet: strobes=%0d outputs=%0d cycles=%0d, required 0 0 2", strobe_cnt, out_cnt, bus.cycles);
    end
  endtask

  task automatic test_reset_mid_run;
    int t;
    halt_after = 1000;
    start_session(16'd1, 8'd0, 8'd0);
    exp_imem.push_back({16'd0, 9'h155}); send_word(9'h155);
    t = 0;
    @(negedge clk);
    while (bus.cycles !== 16'd3 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #1;
    bus.n_inst = 16'd5;
    bus.go     = 1'b1;
    @(posedge clk); #1;
    bus.go     = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_start, bus.busy, bus.in_ready} !== 3'b010 || bus.cycles !== 16'd5) begin
      errors++;
      $display("FAIL go_ignored: {cpu_start,busy,in_ready}=%b cycles=%0d, required 010 and 5",
               {bus.cpu_start, bus.busy, bus.in_ready}, bus.cycles);
    end
    start = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cpu_start, bus.busy, bus.done} !== 3'b100 || bus.cycles !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: {cpu_start,busy,done}=%b cycles=%0d, required 100 and 0",
               {bus.cpu_start, bus.busy, bus.done}, bus.cycles);
    end
    start = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    halt_after = 100000;
    bus.out_ready = 1'b1;
`ifdef LOADER_TIMEOUT_EN
    exp_out.push_back(8'h3C);
`endif
    start_session(16'd0, 8'd1, 8'd1);
    exp_dmem.push_back({8'd0, 8'h3C}); send_word(9'h03C);
`ifdef LOADER_TIMEOUT_EN
    wait_done(200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo_done: done=%b, required 1 within 200 cycles", bus.done);
    end
    checks++;
    if (bus.timeout !== 1'b1 || bus.cycles !== 16'd20 || exp_out.size() != 0) begin
      errors++;
      $display("FAIL tmo_state: timeout=%b cycles=%0d pending=%0d, required 1 20 0",
               bus.timeout, bus.cycles, exp_out.size());
    end
`else
    ok = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if ({bus.busy, bus.cpu_start, bus.done, bus.timeout} !== 4'b1000 || ok) begin
      errors++;
      $display("FAIL no_tmo: {busy,cpu_start,done,timeout}=%b, required 1000",
               {bus.busy, bus.cpu_start, bus.done, bus.timeout});
    end
    checks++;
    if (!(bus.cycles > 16'd20)) begin
      errors++;
      $display("FAIL no_tmo_cycles: cycles=%0d, required above 20", bus.cycles);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`endif
    checks++;
    if (exp_dmem.size() != 0) begin
      errors++;
      $display("FAIL tmo_load: pending dmem=%0d, required 0", exp_dmem.size());
    end
  endtask

  initial begin
    start         = 1'b1;
    bus.go        = 1'b0;
    bus.n_inst    = 16'd0;
    bus.n_data    = 8'd0;
    bus.n_dump    = 8'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 9'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_full_session();
    test_backpressure();
    test_zero_counts();
    test_reset_mid_run();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameters: IW=9 (instruction width); IA=16 (instruction address width); DW=8 (data width); DA=8 (data address width); MAXCYC=16'hFFFF (run timeout, cycles).
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  single clock; all state changes on posedge.
- start  in  1  reset, synchronous, active-high.
- go  in  1  begin session; accepted only in IDLE or DONE.
- n_inst  in  IA  instruction words to load; sampled when go is accepted.
- n_data  in  DA  data bytes to preload; sampled when go is accepted.
- n_dump  in  DA  data bytes to read back; sampled when go is accepted.
- in_valid / in_ready  in / out  1 / 1  load-stream handshake.
- in_data  in  IW  load word; data bytes use [7:0].
- imem_we / imem_addr / imem_wdata  out  1 / IA / IW  instruction memory write port.
- dmem_we / dmem_re / dmem_addr / dmem_wdata  out  1 / 1 / DA / DW  data memory port.
- dmem_rdata  in  DW  read data, valid the cycle after dmem_re.
- cpu_start  out  1  CPU reset/start.
- cpu_halt  in  1  CPU halt.
- out_valid / out_ready  out / in  1 / 1  dump-stream handshake.
- out_data  out  DW  dumped byte.
- cycles  out  16  CPU run-cycle count.
- busy / done / timeout  out  1 / 1 / 1  status.

Function
REQ-003 States: IDLE, LOAD_I, LOAD_D, START, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-004 On go accepted, the state SHALL become LOAD_I, LOAD_D, START in that order of preference, skipping any load phase whose count is 0; go in any other state is ignored.
REQ-005 In LOAD_I and LOAD_D, in_ready=1; in all other states, in_ready=0.
REQ-006 In LOAD_I, each in_valid&in_ready cycle SHALL drive imem_we=1, imem_addr=index, imem_wdata=in_data in that same cycle; the index starts at 0 and increments per word; after word n_inst-1, the state SHALL become LOAD_D, or START if n_data=0.
REQ-007 In LOAD_D, each handshake SHALL write dmem at index with in_data[7:0]; after byte n_data-1, the state SHALL become START.
REQ-008 cpu_start SHALL be 1 in IDLE, LOAD_I, LOAD_D and START, and 0 in all other states; START SHALL last exactly 2 cycles.
REQ-009 In RUN, cycles SHALL clear on entry, then increment once per cycle while cpu_halt=0, saturating at 16'hFFFF.
REQ-010 In RUN, the first cycle with cpu_halt=1 SHALL move to DUMP_RD, or to DONE if n_dump=0; cpu_halt outside RUN is ignored.
REQ-011 In DUMP_RD, dmem_re=1 and dmem_addr=k for exactly one cycle, then the state SHALL become DUMP_OUT.
REQ-012 In DUMP_OUT, out_data SHALL hold the registered dmem_rdata and out_valid=1 until out_ready=1; on handshake, k increments, and the state SHALL become DUMP_RD, or DONE after byte n_dump-1.
REQ-013 Memory write enables SHALL never be asserted outside LOAD_I/LOAD_D; dmem_we and dmem_re are never both 1.
REQ-014 busy=1 in every state except IDLE and DONE; done=1 in DONE only; DONE is held until the next go.
REQ-015 cycles and timeout SHALL hold their values through DUMP and DONE, and clear when go is accepted.

Reset
REQ-016 When start=1 at a clock edge, regardless of state (including mid-load or mid-run), the block SHALL go to IDLE with:
- cpu_start=1;
- all counters 0 and cycles=0;
- in_ready, out_valid, imem_we, dmem_we, dmem_re, busy, done, timeout all 0;
- out_data=0.

Configuration
REQ-017 With LOADER_TIMEOUT_EN defined, RUN SHALL exit to the dump path when cycles reaches MAXCYC without a halt, setting timeout=1.
REQ-018 Without LOADER_TIMEOUT_EN, RUN SHALL wait indefinitely for cpu_halt, and timeout SHALL be tied to 0.

Verification
REQ-019 Full session:
- Stimulus: n_inst=3, n_data=2, n_dump=2; stream 9'h1A5, 9'h040, 9'h1FF, 8'h11, 8'h22 back-to-back; CPU model halts after 10 run cycles.
- Response: imem[0..2] and dmem[0..1] written; cpu_start 1→0 after 2 START cycles; cycles=10; out_data 8'h11 then 8'h22; done=1.
REQ-020 Backpressure: in_valid toggled every other cycle and out_ready held low for 5 cycles → no lost or duplicated writes; out_data stable while out_valid=1 and out_ready=0.
REQ-021 Zero counts: n_inst=0, n_data=0, n_dump=0 → IDLE→START→RUN→DONE; no memory strobes asserted.
REQ-022 Reset mid-run: start=1 during RUN at cycles=5 → next cycle IDLE, cpu_start=1, busy=0, cycles=0.
REQ-023 Timeout (LOADER_TIMEOUT_EN, MAXCYC=20), halt never asserted → timeout=1, cycles=20, dump completes, done=1; same stimulus without the macro → remains in RUN, timeout=0.
